// File: rtl/mem_pkg.sv
// Encodings and helpers shared by the data-memory access path:
// access sizes, FSM states, alignment check and store lane packing.
package mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_FIN  = 2'b10;
    localparam logic [1:0] ST_ERR  = 2'b11;

    typedef struct packed {
        logic       we;
        logic [1:0] lane;
        logic [1:0] size;
        logic       is_unsigned;
    } req_t;

    // The reserved size code is treated as misaligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] addr_lo, input logic [1:0] size);
        case (size)
            SZ_BYTE: return 4'b0001 << addr_lo;
            SZ_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [31:0] wdata, input logic [1:0] size);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction
endpackage

// File: rtl/load_extend.sv
// Combinational load lane select with sign/zero extension.
// Kept standalone so other memory front ends can share it.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        is_unsigned_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata_i[{addr_i, 3'b000} +: 8];
        half_lane = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            SZ_BYTE: data_o = {{24{byte_lane[7] & ~is_unsigned_i}}, byte_lane};
            SZ_HALF: data_o = {{16{half_lane[15] & ~is_unsigned_i}}, half_lane};
            default: data_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle data-memory access unit: req/ack handshake to a word-wide
// memory, byte/half/word loads with extension, lane-masked stores, timeout.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic        busy,
    output logic [31:0] MemData,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             req_q, req_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      data_q, data_d;
    logic             misalign_q, misalign_d;
    logic [31:0]      load_data;

    load_extend u_load_extend (
        .rdata_i       (mem_rdata),
        .addr_i        (req_q.lane),
        .size_i        (req_q.size),
        .is_unsigned_i (req_q.is_unsigned),
        .data_o        (load_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        misalign_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_misaligned(addr[1:0], size)) begin
                        state_d    = ST_ERR;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        cnt_d   = '0;
                        req_d   = '{we: MemWrite, lane: addr[1:0], size: size, is_unsigned: is_unsigned};
                        addr_d  = {addr[31:2], 2'b00};
                        be_d    = byte_enables(addr[1:0], size);
                        wdata_d = replicate(wdata, size);
                    end
                end
            end
            ST_REQ: begin
                // An ack on the final counted cycle still completes the access.
                if (mem_ack) begin
                    state_d = ST_FIN;
                    if (!req_q.we) begin
                        data_d = load_data;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIN: state_d = ST_IDLE;
            default: begin
                // A misaligned start spends one quiet cycle in ERR so its
                // error pulse lands where a zero-wait access would signal done.
                state_d = misalign_q ? ST_ERR : ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            misalign_q <= misalign_d;
        end
    end

    assign busy      = state_q != ST_IDLE;
    assign done      = state_q == ST_FIN;
    assign err       = (state_q == ST_ERR) && !misalign_q;
    assign mem_req   = state_q == ST_REQ;
    assign mem_we    = mem_req & req_q.we;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign MemData   = data_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses push expected
// responses; a memory responder and a monitor pop and compare independently.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int TIMEOUT = 16;
    localparam logic [1:0] K_DONE = 2'b10;
    localparam logic [1:0] K_ERR  = 2'b01;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  size = '0;
    logic        is_unsigned = 1'b0;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] MemData, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    typedef struct {
        logic [1:0]  kind;
        int          start_cyc;
        int          lat;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        int          len;
    } mreq_t;

    resp_t exp_q[$];
    mreq_t req_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;

    mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .MemWrite(MemWrite),
        .addr(addr), .wdata(wdata), .size(size), .is_unsigned(is_unsigned),
        .busy(busy), .MemData(MemData), .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Memory model: acks after the scripted number of waits, ack=1 while idle.
    mreq_t cur;
    bit    active = 0;
    bit    cur_valid = 0;
    int    req_len = 0;
    always @(negedge clk) begin
        if (reset) begin
            mem_ack = 1'b0;
            active  = 0;
            req_len = 0;
        end else if (mem_req) begin
            if (!active) begin
                active  = 1;
                req_len = 0;
                if (req_q.size() == 0) begin
                    flag("unexpected_mem_req");
                    cur_valid = 0;
                    cur = '{we: 1'b0, addr: '0, be: '0, wdata: '0, waits: 0, rdata: '0, len: 0};
                end else begin
                    cur_valid = 1;
                    cur = req_q.pop_front();
                    check("mem_we", 32'(mem_we), 32'(cur.we));
                    check("mem_addr", mem_addr, cur.addr);
                    check("mem_be", 32'(mem_be), 32'(cur.be));
                    check("mem_wdata", mem_wdata, cur.wdata);
                end
            end
            mem_ack   = (req_len == cur.waits);
            mem_rdata = mem_ack ? cur.rdata : ~cur.rdata;
            req_len++;
        end else begin
            mem_ack   = 1'b1;
            mem_rdata = 32'h5A5A_5A5A;
            if (active) begin
                if (cur_valid) check("mem_req_cycles", 32'(req_len), 32'(cur.len));
                active = 0;
            end
        end
    end

    bit prev_busy = 0;
    bit fin_prev = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 0;
            fin_prev  = 0;
        end else begin
            if (busy && !prev_busy) begin
                if (exp_q.size() == 0) flag("unexpected_busy");
                else check("busy_rise_cycle", 32'(cyc), 32'(exp_q[0].start_cyc + 1));
            end
            if (!busy && prev_busy) check("busy_fall_after_pulse", 32'(fin_prev), 32'd1);
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    flag("unexpected_response");
                end else begin
                    resp_t e;
                    e = exp_q.pop_front();
                    check("resp_kind", 32'({done, err}), 32'(e.kind));
                    check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
                    check("MemData", MemData, e.data);
                    check("busy_at_resp", 32'(busy), 32'd1);
                    $display("txn start=%0d kind=%b MemData=%h", e.start_cyc, {done, err}, MemData);
                end
            end
            fin_prev  = done || err;
            prev_busy = busy;
        end
    end

    task automatic launch(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input logic uns, input bit acc, input int waits,
                          input logic [31:0] rd, input logic [1:0] kind, input int lat,
                          input logic [31:0] exp_data, input logic [31:0] exp_addr,
                          input logic [3:0] be, input logic [31:0] exp_wd, input int len);
        MemWrite    = we;
        addr        = a;
        wdata       = wd;
        size        = sz;
        is_unsigned = uns;
        start       = 1'b1;
        exp_q.push_back('{kind: kind, start_cyc: cyc, lat: lat, data: exp_data});
        if (acc) req_q.push_back('{we: we, addr: exp_addr, be: be, wdata: exp_wd,
                                   waits: waits, rdata: rd, len: len});
        @(negedge clk);
        start = 1'b0;
    endtask

    // overlap_at > 0 pulses a start that must be ignored while busy.
    task automatic wait_idle(input int overlap_at);
        int i = 1;
        while (exp_q.size() != 0 && i < 200) begin
            start = (i == overlap_at);
            if (start) begin
                MemWrite = 1'b0;
                addr     = 32'h80;
                size     = SZ_WORD;
            end
            @(negedge clk);
            i++;
        end
        start = 1'b0;
        if (exp_q.size() != 0) begin
            flag("wait_for_response_timeout");
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_err", 32'({done, err}), 32'd0);
        check("rst_req_we", 32'({mem_req, mem_we}), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_MemData", MemData, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        launch(0, 32'h10, 0, SZ_WORD, 0, 1, 2, 32'hDEADBEEF, K_DONE, 4, 32'hDEADBEEF, 32'h10, 4'b1111, 0, 3);
        wait_idle(0);
        launch(0, 32'h21, 0, SZ_BYTE, 0, 1, 0, 32'h0000_8000, K_DONE, 2, 32'hFFFFFF80, 32'h20, 4'b0010, 0, 1);
        wait_idle(0);
        launch(0, 32'h21, 0, SZ_BYTE, 1, 1, 1, 32'h0000_8000, K_DONE, 3, 32'h00000080, 32'h20, 4'b0010, 0, 2);
        wait_idle(0);
        launch(1, 32'h32, 32'h1234ABCD, SZ_HALF, 0, 1, 1, 32'hFFFFFFFF, K_DONE, 3, 32'h00000080, 32'h30, 4'b1100, 32'hABCDABCD, 2);
        wait_idle(0);
        launch(0, 32'h22, 0, SZ_HALF, 0, 1, 0, 32'h8001_7FFF, K_DONE, 2, 32'hFFFF8001, 32'h20, 4'b1100, 0, 1);
        wait_idle(0);
        launch(1, 32'h13, 32'h0000_00A5, SZ_BYTE, 0, 1, 0, 32'h0, K_DONE, 2, 32'hFFFF8001, 32'h10, 4'b1000, 32'hA5A5A5A5, 1);
        wait_idle(0);
        launch(0, 32'h41, 0, SZ_WORD, 0, 0, 0, 0, K_ERR, 2, 32'hFFFF8001, 0, 4'b0, 0, 0);
        wait_idle(0);
        launch(1, 32'h23, 32'h5555, SZ_HALF, 0, 0, 0, 0, K_ERR, 2, 32'hFFFF8001, 0, 4'b0, 0, 0);
        wait_idle(0);
        launch(0, 32'h40, 0, 2'b11, 0, 0, 0, 0, K_ERR, 2, 32'hFFFF8001, 0, 4'b0, 0, 0);
        wait_idle(0);
        // Ack on the last counted cycle wins over the timeout.
        launch(0, 32'h44, 0, SZ_WORD, 0, 1, TIMEOUT - 1, 32'h0BADF00D, K_DONE, TIMEOUT + 1, 32'h0BADF00D, 32'h44, 4'b1111, 0, TIMEOUT);
        wait_idle(0);
        launch(0, 32'h50, 0, SZ_WORD, 0, 1, 1000, 32'h0, K_ERR, TIMEOUT + 1, 32'h0BADF00D, 32'h50, 4'b1111, 0, TIMEOUT);
        wait_idle(5);
        launch(0, 32'h62, 0, SZ_HALF, 1, 1, 0, 32'h8765_4321, K_DONE, 2, 32'h00008765, 32'h60, 4'b1100, 0, 1);
        wait_idle(0);

        launch(0, 32'h70, 0, SZ_WORD, 0, 1, 1000, 32'h0, K_DONE, 99, 32'h0, 32'h70, 4'b1111, 0, 0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done_err", 32'({done, err}), 32'd0);
        check("midrst_MemData", MemData, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        launch(0, 32'h74, 0, SZ_WORD, 0, 1, 0, 32'h13579BDF, K_DONE, 2, 32'h13579BDF, 32'h74, 4'b1111, 0, 1);
        wait_idle(0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("mem_queue_empty", 32'(req_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multi-cycle data-memory access unit that produces the MemData word consumed by the write-back select stage, which chooses between AluResult and MemData under MemToReg.
- Sits between core datapath/control and a word-wide data memory with a req/ack handshake.
- Performs byte, half and word loads with sign or zero extension, and byte-lane-masked stores.
- Holds the core via busy until the access completes, is rejected as misaligned, or times out.

Parameters:
- TIMEOUT, 16, cycles mem_req may stay high without mem_ack before the access aborts with error; minimum 1.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle access request from control; ignored while busy=1.
- MemWrite  input  1  sampled with start; 1=store, 0=load.
- addr  input  32  byte address, sampled with start.
- wdata  input  32  store data, sampled with start; the low bytes are used for byte/half.
- size  input  2  00=byte, 01=half, 10=word, 11=reserved (treated as misaligned).
- is_unsigned  input  1  1=zero-extend loads, 0=sign-extend.
- busy  output  1  high from the cycle after an accepted start until the done/err cycle inclusive.
- MemData  output  32  extended load result; holds its value until the next completed load.
- done  output  1  one-cycle pulse on successful completion of a load or store.
- err  output  1  one-cycle pulse on misalignment or timeout.
- mem_req  output  1  memory request; held high until mem_ack.
- mem_we  output  1  memory write enable, valid while mem_req=1.
- mem_addr  output  32  word address {addr[31:2],2'b00}.
- mem_be  output  4  byte enables (little-endian lanes).
- mem_wdata  output  32  store data replicated into lanes: byte x4, half x2.
- mem_ack  input  1  memory response, sampled only while mem_req=1.
- mem_rdata  input  32  read word, valid in the mem_ack cycle.

Behaviour:
- Reset: state IDLE; busy, done, err, mem_req and mem_we are 0; mem_addr, mem_be, mem_wdata, MemData and the counter are 0.
- Reset mid-access drops mem_req immediately with no done/err pulse; the access is abandoned.
- States: IDLE, REQ, FIN, ERR.
- IDLE:
  - start=1 with an aligned access registers all request fields and moves to REQ.
  - start=1 with a misaligned access moves to ERR with no memory access.
  - Misaligned means: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
- REQ:
  - mem_req=1 and busy=1; the counter increments each cycle that mem_ack=0.
  - mem_ack=1 completes the access: loads capture the extended data into MemData on that edge; the FSM moves to FIN.
  - Counter reaching TIMEOUT-1 with mem_ack=0 moves to ERR and drops mem_req; MemData is unchanged.
  - mem_ack in the same cycle as the timeout wins, and the access completes normally.
- FIN: done=1 for one cycle, busy=1; then IDLE.
- ERR: err=1 for one cycle, busy=1; then IDLE.
- Timing: start in cycle 0 gives mem_req high in cycle 1. An ack in cycle 1 gives done in cycle 2. Minimum access is 3 cycles start-to-IDLE.
- Load extract:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Sign extension uses bit 7 or bit 15 of the selected lane; is_unsigned forces zero fill.
- mem_be:
  - Byte: one-hot at addr[1:0].
  - Half: 0011 or 1100.
  - Word: 1111.
  - Loads drive the same enables.
- start while busy=1 is ignored and not queued.
- mem_ack while mem_req=0 is ignored.
- The counter clears on entry to REQ.

Decomposition:
- Shared package mem_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state encodings, and a function for the alignment check.
- One sub-module, load_extend: combinational lane select plus sign/zero extension (inputs rdata, addr[1:0], size, is_unsigned). It is reused later by any cache front end.

Test Plan:
- Word load: start, addr=0x10, size=10; memory acks after 2 waits with rdata=0xDEADBEEF. Required: mem_addr=0x10, mem_be=1111, done 4 cycles after start, MemData=0xDEADBEEF, busy low next cycle.
- Signed/unsigned byte: rdata=0x00008000 at addr=0x21.
  - Signed: MemData=0xFFFFFF80.
  - Unsigned: MemData=0x00000080.
  - Both: mem_be=0010.
- Half store: addr=0x32, wdata=0x1234ABCD, size=01. Required: mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, done pulse, MemData unchanged.
- Misaligned: word at addr=0x41. Required: err pulse in cycle 2, mem_req never asserted, busy high cycles 1–2.
- Timeout and overlap: with TIMEOUT=16 and no ack, mem_req is high exactly 16 cycles, then err. A second start during busy is ignored. A following valid load then completes normally.
- Reset mid-REQ: after 3 wait cycles, mem_req, busy, done and err are 0 immediately. The next start behaves as from a fresh reset.
